imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Multi-cycle memory responder on the far side of the fetch stage's instruction-memory request interface.
- Accepts word-aligned read/write requests and returns data after a programmable latency.
- Signals Stall while busy and pulses Done on completion, so the fetch stage can hold its PC and insert NOPs.
- Data-side instantiation uses the same block; Wr is tied low for instruction use.

Parameters:
- DEPTH_W, 13, log2 of word count (8192 x 16-bit words).
- LATENCY, 4, cycles from request acceptance to Done; legal range 1..15.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- Addr  input  16  byte address; bit 0 must be 0.
- DataIn  input  16  write data.
- Rd  input  1  read request.
- Wr  input  1  write request.
- DataOut  output  16  read data; valid when Done=1 for a read.
- Done  output  1  one-cycle completion pulse.
- Stall  output  1  busy; new requests are ignored while high.
- Err  output  1  one-cycle pulse on an illegal request.

Behaviour:
- Reset values: DataOut=0, Done=0, Stall=0, Err=0, state=IDLE, counter=0. Array contents are not cleared by reset.
- State machine states: IDLE, BUSY. All outputs are registered.
- Request acceptance:
  - A request is accepted on the rising edge of cycle T when state=IDLE (or the Done cycle) and exactly one of Rd/Wr is high with Addr[0]=0.
  - Addr, DataIn and op are latched. Counter loads LATENCY-1. Next state is BUSY if LATENCY>1.
- Latency:
  - Stall=1 in cycles T+1 .. T+LATENCY-1.
  - Done=1 and Stall=0 in cycle T+LATENCY.
  - LATENCY=1: Done at T+1; Stall never asserts.
- Read: DataOut = mem[latched Addr[DEPTH_W:1]], presented in the Done cycle. DataOut holds until the next read Done. A write completion leaves DataOut unchanged.
- Write: array updated at the edge that raises Done. A read of the same address accepted in the Done cycle returns the new data.
- Back-to-back: a request presented during the Done cycle is accepted; no idle bubble is required.
- Requests during Stall=1 are ignored. The initiator holds Rd/Wr/Addr stable until Done.
- Illegal requests, in IDLE or the Done cycle:
  - Rd&Wr both high, or Rd|Wr with Addr[0]=1: Err=1 at T+1 for one cycle.
  - No access is performed, no Done, no Stall, state stays IDLE.
- Address wrap: Addr[15:DEPTH_W+1] ignored; address 0x4000 aliases 0x0000 at the default depth.
- Counter: 4-bit down-counter; Done is asserted when it reaches 0 in BUSY.
- Reset mid-operation: the operation is aborted, a pending write is not committed, outputs return to reset values immediately.

Optional Feature:
- Macro: IMEM_RAND_STALL_EN.
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 0xA5 on reset, steps every cycle) adds lfsr[1:0] extra cycles to each accepted request. Effective latency is LATENCY..LATENCY+3, which exercises the fetch stall path.
- Not defined: latency is exactly LATENCY and no LFSR logic exists.

Decomposition:
- Shared package wisc_mem_pkg holds:
  - state encodings IDLE=1'b0, BUSY=1'b1;
  - LFSR seed and tap constants;
  - word-address width helper constants.
- One sub-module is natural: imem_lfsr8 (clk, rst, step, value[7:0]), instantiated only under IMEM_RAND_STALL_EN.

Test Plan:
- Reset then idle: rst pulse mid-simulation -> DataOut=0x0000, Done=0, Stall=0, Err=0 on the same cycle rst rises.
- Write/read, LATENCY=4:
  - Wr Addr=0x0010 DataIn=0xBEEF at T -> Stall=1 T+1..T+3, Done=1 at T+4.
  - Rd 0x0010 accepted at T+4 -> DataOut=0xBEEF with Done at T+8.
- Back-to-back reads: Rd 0x0000 then Rd 0x0002 (preloaded 0x1111/0x2222) -> Done at T+4 with 0x1111, Done at T+8 with 0x2222, no idle cycle between.
- Illegal requests:
  - Rd Addr=0x0003 -> Err=1 at T+1 only; no Done, Stall=0.
  - Rd=Wr=1 -> same response; memory unchanged.
- Abort and alias:
  - Wr 0x0020=0x5555, rst asserted at T+2 -> reading 0x0020 returns the prior value.
  - Rd 0x4010 returns the mem[0x0010] value.
- With IMEM_RAND_STALL_EN: 64 random reads -> every Done occurs 4..7 cycles after acceptance, data matches the model, and Stall is high on every intervening cycle.

Source files
------------

// File: rtl/wisc_mem_pkg.sv
// Shared definitions for the instruction/data memory responder.
//   - FSM state encoding (IDLE / BUSY)
//   - LFSR seed and tap mask used by the random-stall option
//   - Bus widths and latency-counter width
// Build option: IMEM_RAND_STALL_EN widens the latency counter by one bit so it
// can hold LATENCY-1 plus up to 3 extra random cycles.
package wisc_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } memState_t;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  // Byte address bit 0 selects a byte within a 16-bit word; it must be zero.
  localparam int BYTE_OFFSET_W = 1;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 (1-based) -> bit indices 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

`ifdef IMEM_RAND_STALL_EN
  localparam int CNT_W = 5;
`else
  localparam int CNT_W = 4;
`endif

endpackage

// File: rtl/imem_lfsr8.sv
// 8-bit Fibonacci LFSR used to add random extra latency to memory requests.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset (loads LFSR_SEED)
//   step  - advance one position when high
//   value - current LFSR contents
module imem_lfsr8
  import wisc_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [7:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= LFSR_SEED;
    end else if (step) begin
      value <= {value[6:0], ^(value & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Multi-cycle memory responder behind the fetch stage's instruction-memory
// request interface (also reused on the data side with Wr tied low/high as
// needed). Accepts one word-aligned read or write, holds Stall while the
// access is in flight and pulses Done when it completes.
//
// Ports:
//   clk     - system clock
//   rst     - asynchronous active-high reset
//   Addr    - byte address, bit 0 must be 0; bits above DEPTH_W are ignored
//   DataIn  - write data
//   Rd, Wr  - request strobes, exactly one may be high
//   DataOut - read data, valid with Done for a read, held until next read
//   Done    - one-cycle completion pulse
//   Stall   - busy; requests are ignored while high
//   Err     - one-cycle pulse for an illegal request
//
// Build option: IMEM_RAND_STALL_EN adds 0..3 random cycles (from imem_lfsr8)
// to every accepted request.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready; also the Done cycle, so back-to-back requests are taken
// BUSY  | access in flight, latency counter running down to zero
module imem_responder
  import wisc_mem_pkg::*;
#(
  parameter int DEPTH_W = 13,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Rd,
  input  logic              Wr,
  output logic [DATA_W-1:0] DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              Err
);

  localparam int WORDS = 1 << DEPTH_W;

  memState_t state, nextState;
  logic [CNT_W-1:0] count, nextCount;
  logic [CNT_W-1:0] totalLat, loadCount;

  logic [DEPTH_W-1:0] addrQ;
  logic [DATA_W-1:0]  dataQ;
  logic               opWrQ;

  logic legalReq, accept, illegal;
  logic finishBusy, finishNow, complete;
  logic [DEPTH_W-1:0] cmpAddr;
  logic [DATA_W-1:0]  cmpData;
  logic               cmpWr;
  logic               memWe, rdEn;

  logic [DATA_W-1:0] mem [0:WORDS-1];
  logic [DATA_W-1:0] rdWord;
  logic              dataValid;

  logic unusedAddrHi;
  assign unusedAddrHi = ^Addr[ADDR_W-1:DEPTH_W+BYTE_OFFSET_W];

`ifdef IMEM_RAND_STALL_EN
  logic [7:0] lfsrValue;
  logic       unusedLfsrHi;

  imem_lfsr8 uLfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (1'b1),
    .value (lfsrValue)
  );

  assign unusedLfsrHi = ^lfsrValue[7:2];
  assign totalLat     = CNT_W'(LATENCY) + CNT_W'(lfsrValue[1:0]);
`else
  assign totalLat = CNT_W'(LATENCY);
`endif

  assign loadCount = totalLat - CNT_W'(1);

  assign legalReq = (Rd ^ Wr) & ~Addr[0];
  assign accept   = (state == IDLE) & legalReq;
  assign illegal  = (state == IDLE) & (Rd | Wr) & ~legalReq;

  // A one-cycle access completes at the accepting edge, straight from the
  // request inputs; longer ones complete from the latched copy.
  assign finishBusy = (state == BUSY) & (count == CNT_W'(1));
  assign finishNow  = accept & (loadCount == '0);
  assign complete   = finishBusy | finishNow;

  assign cmpAddr = finishBusy ? addrQ : Addr[DEPTH_W:BYTE_OFFSET_W];
  assign cmpData = finishBusy ? dataQ : DataIn;
  assign cmpWr   = finishBusy ? opWrQ : Wr;

  // Gating with rst keeps an aborted write out of the array.
  assign memWe = complete & cmpWr & ~rst;
  assign rdEn  = complete & ~cmpWr & ~rst;

  always_comb begin
    nextState = state;
    nextCount = count;
    case (state)
      IDLE: begin
        if (accept) begin
          nextCount = loadCount;
          if (loadCount != '0) nextState = BUSY;
        end
      end
      BUSY: begin
        nextCount = count - CNT_W'(1);
        if (count == CNT_W'(1)) nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
        nextCount = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      Done      <= 1'b0;
      Stall     <= 1'b0;
      Err       <= 1'b0;
      dataValid <= 1'b0;
      addrQ     <= '0;
      dataQ     <= '0;
      opWrQ     <= 1'b0;
    end else begin
      state <= nextState;
      count <= nextCount;
      Done  <= complete;
      Stall <= (nextState == BUSY);
      Err   <= illegal;
      if (complete & ~cmpWr) dataValid <= 1'b1;
      if (accept) begin
        addrQ <= Addr[DEPTH_W:BYTE_OFFSET_W];
        dataQ <= DataIn;
        opWrQ <= Wr;
      end
    end
  end

  // Array and read register carry no reset so they map onto block RAM;
  // dataValid forces DataOut to zero until the first read after reset.
  always_ff @(posedge clk) begin
    if (memWe) mem[cmpAddr] <= cmpData;
    if (rdEn)  rdWord <= mem[cmpAddr];
  end

  assign DataOut = dataValid ? rdWord : '0;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  localparam int DEPTH_W = 13;
  localparam int LATENCY = 4;
`ifdef IMEM_RAND_STALL_EN
  localparam int MAX_EXTRA = 3;
`else
  localparam int MAX_EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] Addr = 16'h0;
  logic [15:0] DataIn = 16'h0;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic [15:0] DataOut;
  logic        Done, Stall, Err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  imem_responder #(.DEPTH_W(DEPTH_W), .LATENCY(LATENCY)) dut (
    .clk     (clk),
    .rst     (rst),
    .Addr    (Addr),
    .DataIn  (DataIn),
    .Rd      (Rd),
    .Wr      (Wr),
    .DataOut (DataOut),
    .Done    (Done),
    .Stall   (Stall),
    .Err     (Err)
  );

  // ---------------- behavioural model (transaction / cycle-number based) ----
  logic [15:0] mMem [int];
  bit          eDone, eStall, eErr;
  logic [15:0] eData = 16'h0;
  bit          mBusy, mWasBusy, mOpWr;
  longint      mCyc, mDoneAt;
  int          mLat, mWord;
  logic [15:0] mWData;
  logic [7:0]  mLfsr;

  function automatic int wordOf(input logic [15:0] a);
    return (int'(a) / 2) % (1 << DEPTH_W);
  endfunction

  task automatic modelFinish();
    eDone = 1'b1;
    if (mOpWr) mMem[mWord] = mWData;
    else if (mMem.exists(mWord)) eData = mMem[mWord];
    else eData = 16'hxxxx;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eDone = 0; eStall = 0; eErr = 0; eData = 16'h0;
      mBusy = 0; mCyc = 0; mLfsr = 8'hA5;
    end else begin
      mWasBusy = mBusy;
      mCyc++;
      eDone = 0; eStall = 0; eErr = 0;
      if (mBusy) begin
        if (mCyc == mDoneAt) begin
          mBusy = 0;
          modelFinish();
        end else begin
          eStall = 1;
        end
      end
      if (!mWasBusy && (Rd || Wr)) begin
        if ((Rd && Wr) || Addr[0]) begin
          eErr = 1;
        end else begin
          mLat = LATENCY + ((MAX_EXTRA != 0) ? int'(mLfsr % 4) : 0);
          mOpWr = Wr; mWord = wordOf(Addr); mWData = DataIn;
          mDoneAt = mCyc - 1 + mLat;
          if (mLat == 1) modelFinish();
          else begin mBusy = 1; eStall = 1; end
        end
      end
      mLfsr = {mLfsr[6:0], mLfsr[7] ^ mLfsr[5] ^ mLfsr[4] ^ mLfsr[3]};
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    vectors++;
    if (Done !== eDone || Stall !== eStall || Err !== eErr || DataOut !== eData) begin
      miscompares++;
      $display("FAIL cycle_check t=%0t: got Done=%b Stall=%b Err=%b DataOut=%h, expected Done=%b Stall=%b Err=%b DataOut=%h",
               $time, Done, Stall, Err, DataOut, eDone, eStall, eErr, eData);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d,
                       input bit b2b, output int n);
    bit latOk;
    if (!b2b) @(negedge clk);
    Rd = r; Wr = w; Addr = a; DataIn = d;
    n = 0;
    if ((r && w) || ((r || w) && a[0])) begin
      @(negedge clk);
      n = 1;
      Rd = 0; Wr = 0;
      return;
    end
    do begin
      @(negedge clk);
      n++;
    end while (!Done && n < 40);
    vectors++;
    if (!Done) begin
      miscompares++;
      $display("FAIL done_timeout: no Done after %0d cycles, expected within %0d", n, LATENCY + MAX_EXTRA);
    end else begin
      latOk = (n >= LATENCY) && (n <= LATENCY + MAX_EXTRA);
      if (!latOk) begin
        miscompares++;
        $display("FAIL latency: got %0d cycles expected %0d..%0d", n, LATENCY, LATENCY + MAX_EXTRA);
      end
    end
    Rd = 0; Wr = 0;
  endtask

  logic [15:0] initVals [32];

  initial begin
    int n;
    logic [15:0] a;
    int kind, word, hi;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_dataout", DataOut, 16'h0000);
    chk("reset_done", {15'h0, Done}, 16'h0);
    chk("reset_stall", {15'h0, Stall}, 16'h0);
    chk("reset_err", {15'h0, Err}, 16'h0);

    // preload a 32-word window
    for (int i = 0; i < 32; i++) begin
      initVals[i] = (i == 0) ? 16'h1111 : (i == 1) ? 16'h2222 : 16'($urandom);
      issue(1'b0, 1'b1, 16'(i * 2), initVals[i], bit'(i % 2), n);
    end

    // write then back-to-back read
    issue(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, n);
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, n);
    chk("rd_after_wr", DataOut, 16'hBEEF);

    // back-to-back reads
    issue(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, n);
    chk("b2b_rd0", DataOut, 16'h1111);
    issue(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, n);
    chk("b2b_rd1", DataOut, 16'h2222);

    // misaligned read
    @(negedge clk);
    Rd = 1'b1; Addr = 16'h0003;
    @(negedge clk);
    chk("odd_err", {15'h0, Err}, 16'h1);
    chk("odd_stall", {15'h0, Stall}, 16'h0);
    chk("odd_done", {15'h0, Done}, 16'h0);
    Rd = 1'b0;
    @(negedge clk);
    chk("odd_err_clear", {15'h0, Err}, 16'h0);

    // Rd and Wr together must not write
    Rd = 1'b1; Wr = 1'b1; Addr = 16'h0010; DataIn = 16'h0000;
    @(negedge clk);
    chk("both_err", {15'h0, Err}, 16'h1);
    Rd = 1'b0; Wr = 1'b0;
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, n);
    chk("both_mem_unchanged", DataOut, 16'hBEEF);

    // aborted write
    @(negedge clk);
    Wr = 1'b1; Addr = 16'h0020; DataIn = 16'h5555;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    Wr = 1'b0;
    #1;
    chk("abort_dataout", DataOut, 16'h0000);
    chk("abort_done", {15'h0, Done}, 16'h0);
    chk("abort_stall", {15'h0, Stall}, 16'h0);
    chk("abort_err", {15'h0, Err}, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, n);
    chk("abort_prior", DataOut, initVals[16]);

    // alias
    issue(1'b1, 1'b0, 16'h4010, 16'h0000, 1'b0, n);
    chk("alias_rd", DataOut, 16'hBEEF);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      word = $urandom_range(0, 31);
      hi   = $urandom_range(0, 3);
      a    = 16'((hi << 14) | (word << 1));
      if (kind == 0) issue(1'b1, 1'b0, a | 16'h0001, 16'h0, bit'($urandom_range(0, 1)), n);
      else if (kind == 1) issue(1'b1, 1'b1, a, 16'($urandom), bit'($urandom_range(0, 1)), n);
      else if (kind <= 4) issue(1'b0, 1'b1, a, 16'($urandom), bit'($urandom_range(0, 1)), n);
      else issue(1'b1, 1'b0, a, 16'h0, bit'($urandom_range(0, 1)), n);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
